// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive path.
// Data width, default FIFO depth and the pointer-width function.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int UART_FIFO_DEPTH_DEF = 16;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bundle between uart_rx/consumer and uart_rx_fifo.
// master: drives rx_rdy, rx_data, rd_en, ovr_clr; slave: drives
// dout, empty, full, count, overrun (and level_irq when
// UART_RX_FIFO_WATERMARK_EN is defined).
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH_DEF,
    parameter int WIDTH = UART_DATA_W
);

    localparam int CW = ptr_w(DEPTH) + 1;

    logic             rx_rdy;
    logic [WIDTH-1:0] rx_data;
    logic             rd_en;
    logic             ovr_clr;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             overrun;
`ifdef UART_RX_FIFO_WATERMARK_EN
    logic             level_irq;
`endif

    modport master (
`ifdef UART_RX_FIFO_WATERMARK_EN
        input  level_irq,
`endif
        output rx_rdy, rx_data, rd_en, ovr_clr,
        input  dout, empty, full, count, overrun
    );

    modport slave (
`ifdef UART_RX_FIFO_WATERMARK_EN
        output level_irq,
`endif
        input  rx_rdy, rx_data, rd_en, ovr_clr,
        output dout, empty, full, count, overrun
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// Byte storage for the receive FIFO: sync write, async read, no reset.
// Ports: clk, i_we/i_waddr/i_wdata (write), i_raddr/o_rdata (read).
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// FWFT receive FIFO fed by uart_rx rdy rising edges; sticky overrun.
// Ports: clk, rst_n (async low), bus (uart_rx_fifo_if.slave).
// Option UART_RX_FIFO_WATERMARK_EN adds WATERMARK and bus.level_irq.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH_DEF,
    parameter int WIDTH = UART_DATA_W
`ifdef UART_RX_FIFO_WATERMARK_EN
  , parameter int WATERMARK = DEPTH / 2
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_fifo_if.slave bus
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_empty;
    logic             r_full;
    logic             r_ovr;
    logic             r_rdy_q;
    logic [CW-1:0]    w_count_next;
    logic             w_push_req;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic [WIDTH-1:0] w_rdata;

    // rdy_q resets high so a rdy already up at release is stale.
    assign w_push_req = bus.rx_rdy & ~r_rdy_q;
    assign w_pop      = bus.rd_en & ~r_empty;
    // A pop on a full FIFO frees the slot for a same-edge push.
    assign w_push     = w_push_req & (~r_full | w_pop);
    assign w_drop     = w_push_req & r_full & ~w_pop;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + CW'(1);
        else if (!w_push && w_pop)
            w_count_next = r_count - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_ovr    <= 1'b0;
            r_rdy_q  <= 1'b1;
        end else begin
            r_rdy_q <= bus.rx_rdy;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == CW'(DEPTH));
            if (w_drop)
                r_ovr <= 1'b1;
            else if (bus.ovr_clr)
                r_ovr <= 1'b0;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.rx_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign bus.dout    = r_empty ? '0 : w_rdata;
    assign bus.empty   = r_empty;
    assign bus.full    = r_full;
    assign bus.count   = r_count;
    assign bus.overrun = r_ovr;

`ifdef UART_RX_FIFO_WATERMARK_EN
    logic r_level_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_level_irq <= 1'b0;
        else
            r_level_irq <= (w_count_next >= CW'(WATERMARK));
    end

    assign bus.level_irq = r_level_irq;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=16, WIDTH=8).
// Inputs change on the falling edge; outputs are checked there too.
module tb_uart_rx_fifo;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    uart_rx_fifo_if #(.DEPTH(16), .WIDTH(8)) bus ();

    uart_rx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called on a falling edge; returns once rdy is low again in rdy_q.
    task automatic frame(input logic [7:0] d, input int hold);
        bus.rx_data = d;
        bus.rx_rdy  = 1'b1;
        repeat (hold) @(negedge clk);
        bus.rx_rdy  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'h99;
        bus.rd_en   = 1'b0;
        bus.ovr_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (bus.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_empty: got %0b expected 1", bus.empty);
        end
        n_checks++;
        if (bus.count !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", bus.count);
        end
        n_checks++;
        if (bus.dout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_dout: got %0h expected 0", bus.dout);
        end
        n_checks++;
        if (bus.full !== 1'b0 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got full=%0b ovr=%0b expected 0 0",
                     bus.full, bus.overrun);
        end
        bus.rx_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frames();
        logic [7:0] exp [3];
        exp[0] = 8'h7D;
        exp[1] = 8'h2F;
        exp[2] = 8'hC1;
        for (int i = 0; i < 3; i++) frame(exp[i], 5);
        n_checks++;
        if (bus.count !== 5'd3 || bus.empty !== 1'b0) begin
            n_fail++;
            $display("FAIL frames_count: got %0d empty=%0b expected 3 0",
                     bus.count, bus.empty);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.dout !== exp[i]) begin
                n_fail++;
                $display("FAIL frames_pop%0d: got %0h expected %0h",
                         i, bus.dout, exp[i]);
            end
            bus.rd_en = 1'b1;
            @(negedge clk);
            bus.rd_en = 1'b0;
        end
        n_checks++;
        if (bus.empty !== 1'b1 || bus.dout !== 8'h00) begin
            n_fail++;
            $display("FAIL frames_drain: got empty=%0b dout=%0h expected 1 0",
                     bus.empty, bus.dout);
        end
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        n_checks++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL pop_empty: got count=%0d expected 0", bus.count);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 16; i++) frame(8'(i), 1);
        n_checks++;
        if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL fill16: got full=%0b count=%0d ovr=%0b expected 1 16 0",
                     bus.full, bus.count, bus.overrun);
        end
        frame(8'hAA, 1);
        n_checks++;
        if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL drop: got full=%0b count=%0d ovr=%0b expected 1 16 1",
                     bus.full, bus.count, bus.overrun);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (bus.dout !== 8'(i)) begin
                n_fail++;
                $display("FAIL ovr_pop%0d: got %0h expected %0h", i, bus.dout, i);
            end
            bus.rd_en = 1'b1;
            @(negedge clk);
            bus.rd_en = 1'b0;
        end
        n_checks++;
        if (bus.empty !== 1'b1 || bus.overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_sticky: got empty=%0b ovr=%0b expected 1 1",
                     bus.empty, bus.overrun);
        end
        bus.ovr_clr = 1'b1;
        @(negedge clk);
        bus.ovr_clr = 1'b0;
        n_checks++;
        if (bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clr: got %0b expected 0", bus.overrun);
        end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] e;
        for (int i = 0; i < 16; i++) frame(8'h10 + 8'(i), 1);
        bus.rx_data = 8'h55;
        bus.rx_rdy  = 1'b1;
        bus.rd_en   = 1'b1;
        @(negedge clk);
        bus.rx_rdy  = 1'b0;
        bus.rd_en   = 1'b0;
        n_checks++;
        if (bus.count !== 5'd16 || bus.overrun !== 1'b0 || bus.full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pp: got count=%0d ovr=%0b full=%0b expected 16 0 1",
                     bus.count, bus.overrun, bus.full);
        end
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            e = (i == 15) ? 8'h55 : 8'h11 + 8'(i);
            n_checks++;
            if (bus.dout !== e) begin
                n_fail++;
                $display("FAIL full_pp_pop%0d: got %0h expected %0h", i, bus.dout, e);
            end
            bus.rd_en = 1'b1;
            @(negedge clk);
            bus.rd_en = 1'b0;
        end
        n_checks++;
        if (bus.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pp_drain: got empty=%0b expected 1", bus.empty);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        for (int i = 0; i < 20; i++) begin
            d = 8'(i * 3);
            frame(d, 1);
            n_checks++;
            if (bus.count !== 5'd1 || bus.dout !== d) begin
                n_fail++;
                $display("FAIL wrap%0d: got count=%0d dout=%0h expected 1 %0h",
                         i, bus.count, bus.dout, d);
            end
            bus.rd_en = 1'b1;
            @(negedge clk);
            bus.rd_en = 1'b0;
        end
        n_checks++;
        if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
            n_fail++;
            $display("FAIL wrap_drain: got count=%0d expected 0", bus.count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16; i++) frame(8'h40 + 8'(i), 1);
        frame(8'hEE, 1);
        bus.rd_en = 1'b1;
        repeat (11) @(negedge clk);
        bus.rd_en = 1'b0;
        n_checks++;
        if (bus.count !== 5'd5 || bus.overrun !== 1'b1 || bus.dout !== 8'h4B) begin
            n_fail++;
            $display("FAIL pre_rst: got count=%0d ovr=%0b dout=%0h expected 5 1 4b",
                     bus.count, bus.overrun, bus.dout);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.empty !== 1'b1 || bus.count !== 5'd0 || bus.overrun !== 1'b0 ||
            bus.dout !== 8'h00 || bus.full !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst: got empty=%0b count=%0d ovr=%0b dout=%0h expected 1 0 0 0",
                     bus.empty, bus.count, bus.overrun, bus.dout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame(8'h3C, 1);
        n_checks++;
        if (bus.count !== 5'd1 || bus.dout !== 8'h3C) begin
            n_fail++;
            $display("FAIL post_rst: got count=%0d dout=%0h expected 1 3c",
                     bus.count, bus.dout);
        end
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
`ifdef UART_RX_FIFO_WATERMARK_EN
        for (int i = 0; i < 7; i++) frame(8'(i), 1);
        n_checks++;
        if (bus.level_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq7: got %0b expected 0", bus.level_irq);
        end
        frame(8'h07, 1);
        n_checks++;
        if (bus.level_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq8: got %0b expected 1", bus.level_irq);
        end
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_frames();
        test_overrun();
        test_push_pop_full();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
